mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
Shares one output channel between two requesters. A registered round-robin arbiter drives the select of a per-bit 2:1 mux bank. Grants are burst-locked: the owner keeps the channel until its last beat or the burst limit, then ownership is re-arbitrated. Sits between two streaming producers and a single valid/ready consumer.

Parameters:
WIDTH, 8, data width in bits of each requester and of the output channel.
MAX_BURST, 4, maximum beats per grant before forced re-arbitration; must be >= 1.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 has a valid beat
last0  in  1  requester 0 beat is final beat of its burst
data0  in  WIDTH  requester 0 data
ack0  out  1  requester 0 beat accepted this cycle
req1  in  1  requester 1 has a valid beat
last1  in  1  requester 1 beat is final beat of its burst
data1  in  WIDTH  requester 1 data
ack1  out  1  requester 1 beat accepted this cycle
out_valid  out  1  output beat valid
out_data  out  WIDTH  output data = mux of data0/data1 by select
out_last  out  1  output last flag
out_ready  in  1  consumer accepts beat
owner  out  1  current select value (0 = requester 0, 1 = requester 1)
busy  out  1  a grant is active

Behaviour:
- Clocking: one clock domain, clk. rst is asynchronous and active-high. All registers clear immediately on rst=1, independent of clk.
- Registered state: fsm in {IDLE, GNT0, GNT1}; sel; prio (requester favoured on a tie); beat_cnt, width clog2(MAX_BURST+1).
- Reset values: fsm=IDLE, sel=0, prio=0, beat_cnt=0.
- Outputs during reset: out_valid=0, out_last=0, ack0=ack1=0, owner=0, busy=0. out_data = data0, because sel=0.
- IDLE state:
  - busy=0, out_valid=0, ack0=ack1=0.
  - Next state is GNTx when only reqx=1.
  - When req0=req1=1, next state is GNT(prio).
  - Otherwise stay in IDLE.
  - sel loads the winner. Arbitration latency from IDLE is 1 cycle; no beat transfers in the arbitration cycle.
- GNTx state:
  - busy=1, owner=sel=x.
  - out_valid=reqx, out_last=lastx, out_data=datax. This path is combinational, zero latency.
  - ackx = reqx & out_ready; ack of the other requester = 0.
  - A beat transfers when ackx=1; beat_cnt then increments.
  - Release condition: the beat transfers AND (lastx=1 OR beat_cnt==MAX_BURST-1).
  - On release: beat_cnt clears to 0 and prio becomes ~x.
  - On release, if the other requester has req=1, go directly to GNT(~x) with no idle bubble and sel flips. Otherwise go to IDLE.
  - reqx dropping mid-burst does not release the grant; the lock holds until a release condition occurs.
  - reqx=1 with out_ready=0 holds all state (backpressure).
- MAX_BURST=1: every transferred beat releases the grant, giving strict alternation when both requesters are active.
- A new request from the non-owner during a grant has no effect until release.
- Reset asserted mid-burst: the grant is aborted immediately, with no partial-state retention. The consumer sees out_valid fall asynchronously.
- Select changes only on a clock edge. out_data never glitches between requesters within a cycle except through changes to data inputs.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2; helper for counter width.
- Sub-module mux2_bus: a WIDTH-wide 2:1 mux built from a generate loop of single-bit gate-level 2:1 mux cells. It also muxes the valid and last flags. The arbiter FSM stays in the top module.

Test Plan:
- Reset and single requester:
  - Stimulus: rst pulse mid-cycle; then req0=1, data0=0xA5, last0=1, out_ready=1.
  - Required response: all outputs 0 during reset. IDLE for 1 cycle, then out_valid=1, out_data=0xA5, ack0=1 for 1 cycle, then busy=0.
- Tie and round-robin:
  - Stimulus: req0=req1=1 continuously, each burst 2 beats (last on beat 2).
  - Required response: owner sequence 0,0,1,1,0,0…; no idle cycle between bursts; ack1 never asserts while owner=0.
- Burst limit:
  - Stimulus: MAX_BURST=4; req1 held with last1=0 for 10 beats; req0=1 throughout.
  - Required response: owner=1 for exactly 4 transfers, then owner=0.
- Backpressure:
  - Stimulus: owner=0 mid-burst, out_ready=0 for 3 cycles.
  - Required response: ack0=0, beat_cnt and owner unchanged, out_data stable = data0.
- Request drop:
  - Stimulus: owner=1, req1 falls for 2 cycles with no last beat, req0=1.
  - Required response: owner stays 1, out_valid=0, busy=1; grant resumes when req1 returns.
- Reset mid-burst:
  - Stimulus: rst asserted after beat 2 of 4.
  - Required response: busy=0, out_valid=0 immediately (asynchronous). After release with req0=req1=1, owner=0 because prio reset to 0.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
//   state_t   : arbiter FSM encoding (idle, granted to 0, granted to 1)
//   cnt_width : width of the per-grant beat counter for a given burst limit
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    // The counter must hold 0..max_burst, so it needs clog2(max_burst+1) bits.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2_bus.sv
// WIDTH-wide 2:1 mux bank with the valid and last flags carried alongside
// the data bits. Each bit is an AND-OR gate-level mux cell, so the output
// only moves when the select or a data input moves.
//   i_sel              : 0 selects side a, 1 selects side b
//   i_a_* / i_b_*      : data, valid and last of each side
//   o_data/o_valid/o_last : selected side
module mux2_bus
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic             i_a_valid,
    input  logic             i_a_last,
    input  logic [WIDTH-1:0] i_b_data,
    input  logic             i_b_valid,
    input  logic             i_b_last,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_last
);

    localparam int BW = WIDTH + 2;

    logic [BW-1:0] w_a;
    logic [BW-1:0] w_b;
    logic [BW-1:0] w_y;

    assign w_a = {i_a_last, i_a_valid, i_a_data};
    assign w_b = {i_b_last, i_b_valid, i_b_data};

    for (genvar g = 0; g < BW; g++) begin : g_cell
        assign w_y[g] = (w_a[g] & ~i_sel) | (w_b[g] & i_sel);
    end

    assign o_data  = w_y[WIDTH-1:0];
    assign o_valid = w_y[WIDTH];
    assign o_last  = w_y[WIDTH+1];

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared valid/ready channel.
// A grant is burst-locked: the owner keeps the channel until it sends a
// last beat or reaches MAX_BURST beats, then ownership is re-arbitrated.
// If the other side is waiting at that moment it takes over with no idle
// cycle in between.
//   clk, rst               : clock, asynchronous active-high reset
//   req/last/data{0,1}     : requester beats
//   ack{0,1}               : beat of that requester accepted this cycle
//   out_valid/data/last    : shared output channel, out_ready from consumer
//   owner                  : current select (0 = requester 0)
//   busy                   : a grant is active
//
// Handshake: a beat moves when out_valid and out_ready are both high on a
// rising edge; the accepting requester sees its ack high in that same cycle.
// out_valid never waits for out_ready.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             last0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic             last1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             owner,
    output logic             busy
);

    localparam int             CW        = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sel;
    logic            w_sel_nxt;
    logic            r_prio;
    logic            w_prio_nxt;
    logic [CW-1:0]   r_beat_cnt;
    logic [CW-1:0]   w_beat_cnt_nxt;

    logic            w_busy;
    logic            w_mux_valid;
    logic            w_mux_last;
    logic            w_xfer;
    logic            w_release;
    logic            w_other_req;

    mux2_bus #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_sel     (r_sel),
        .i_a_data  (data0),
        .i_a_valid (req0),
        .i_a_last  (last0),
        .i_b_data  (data1),
        .i_b_valid (req1),
        .i_b_last  (last1),
        .o_data    (out_data),
        .o_valid   (w_mux_valid),
        .o_last    (w_mux_last)
    );

    assign w_busy    = (r_state != ST_IDLE);
    assign busy      = w_busy;
    assign owner     = r_sel;
    assign out_valid = w_busy & w_mux_valid;
    assign out_last  = w_busy & w_mux_last;

    assign ack0 = (r_state == ST_GNT0) & req0 & out_ready;
    assign ack1 = (r_state == ST_GNT1) & req1 & out_ready;

    assign w_xfer      = ack0 | ack1;
    // The counter still holds the pre-increment value during the final beat.
    assign w_release   = w_xfer & (w_mux_last | (r_beat_cnt == LAST_BEAT));
    assign w_other_req = r_sel ? req0 : req1;

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_prio_nxt     = r_prio;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_sel_nxt   = r_prio;
                    w_state_nxt = r_prio ? ST_GNT1 : ST_GNT0;
                end else if (req0) begin
                    w_sel_nxt   = 1'b0;
                    w_state_nxt = ST_GNT0;
                end else if (req1) begin
                    w_sel_nxt   = 1'b1;
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_release) begin
                    w_beat_cnt_nxt = '0;
                    w_prio_nxt     = ~r_sel;
                    if (w_other_req) begin
                        w_sel_nxt   = ~r_sel;
                        w_state_nxt = r_sel ? ST_GNT0 : ST_GNT1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             rst;
    logic             req0;
    logic             last0;
    logic [WIDTH-1:0] data0;
    logic             ack0;
    logic             req1;
    logic             last1;
    logic [WIDTH-1:0] data1;
    logic             ack1;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             owner;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    mux2_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .last0     (last0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .last1     (last1),
        .data1     (data1),
        .ack1      (ack1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .owner     (owner),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled one more ns later, well clear of both edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic l0, input logic [WIDTH-1:0] d0,
                         input logic r1, input logic l1, input logic [WIDTH-1:0] d1,
                         input logic rdy);
        req0 = r0; last0 = l0; data0 = d0;
        req1 = r1; last1 = l1; data1 = d1;
        out_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'hC3, 1'b1);
        #1;
        rst = 1'b1;   // mid-cycle, no clock edge involved
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last got=%b exp=0", out_last); else n_pass++;
        n_checks++; if ({ack0, ack1} !== 2'b00) $display("FAIL rst_acks got=%b exp=00", {ack0, ack1}); else n_pass++;
        n_checks++; if (owner !== 1'b0) $display("FAIL rst_owner got=%b exp=0", owner); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (out_data !== 8'h5A) $display("FAIL rst_out_data got=%h exp=5a", out_data); else n_pass++;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        // arbitration cycle: nothing moves yet
        n_checks++; if ({busy, out_valid, ack0} !== 3'b000) $display("FAIL single_arb got busy/valid/ack0=%b exp=000", {busy, out_valid, ack0}); else n_pass++;
        cyc();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", out_data); else n_pass++;
        n_checks++; if ({ack0, ack1} !== 2'b10) $display("FAIL single_ack got=%b exp=10", {ack0, ack1}); else n_pass++;
        n_checks++; if ({busy, owner, out_last} !== 3'b101) $display("FAIL single_state got busy/owner/last=%b exp=101", {busy, owner, out_last}); else n_pass++;
        cyc();
        n_checks++; if ({busy, ack0} !== 2'b00) $display("FAIL single_release got busy/ack0=%b exp=00", {busy, ack0}); else n_pass++;
    endtask

    task automatic test_tie_round_robin();
        logic exp_owner;
        do_reset();
        drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h20, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL tie_arb_busy got=%b exp=0", busy); else n_pass++;
        cyc();
        for (int i = 0; i < 8; i++) begin
            exp_owner = ((i / 2) % 2) == 1;
            drive(1'b1, (i % 2) == 1, 8'(8'h10 + i), 1'b1, (i % 2) == 1, 8'(8'h20 + i), 1'b1);
            n_checks++; if (owner !== exp_owner) $display("FAIL tie_owner beat=%0d got=%b exp=%b", i, owner, exp_owner); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL tie_busy beat=%0d got=%b exp=1", i, busy); else n_pass++;
            n_checks++; if ({ack0, ack1} !== {~exp_owner, exp_owner}) $display("FAIL tie_ack beat=%0d got=%b exp=%b", i, {ack0, ack1}, {~exp_owner, exp_owner}); else n_pass++;
            n_checks++; if (out_data !== (exp_owner ? 8'(8'h20 + i) : 8'(8'h10 + i))) $display("FAIL tie_data beat=%0d got=%h", i, out_data); else n_pass++;
            cyc();
        end
    endtask

    task automatic test_burst_limit();
        do_reset();
        drive(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h80, 1'b1);   // requester 1 wins the idle slot
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
            n_checks++; if ({owner, ack1, ack0} !== 3'b110) $display("FAIL limit_own1 beat=%0d got owner/ack1/ack0=%b exp=110", i, {owner, ack1, ack0}); else n_pass++;
            n_checks++; if (out_data !== 8'(8'h80 + i)) $display("FAIL limit_data beat=%0d got=%h exp=%h", i, out_data, 8'(8'h80 + i)); else n_pass++;
            cyc();
        end
        n_checks++; if ({owner, ack0, ack1, busy} !== 4'b0101) $display("FAIL limit_handover got owner/ack0/ack1/busy=%b exp=0101", {owner, ack0, ack1, busy}); else n_pass++;
        n_checks++; if (out_data !== 8'h01) $display("FAIL limit_handover_data got=%h exp=01", out_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc();
        n_checks++; if (ack0 !== 1'b1) $display("FAIL bp_first_ack got=%b exp=1", ack0); else n_pass++;
        cyc();  // one beat taken, counter at 1
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h99, 1'b0);
            n_checks++; if ({ack0, ack1} !== 2'b00) $display("FAIL bp_ack cyc=%0d got=%b exp=00", i, {ack0, ack1}); else n_pass++;
            n_checks++; if ({owner, busy, out_valid} !== 3'b011) $display("FAIL bp_state cyc=%0d got owner/busy/valid=%b exp=011", i, {owner, busy, out_valid}); else n_pass++;
            n_checks++; if (out_data !== 8'h3C) $display("FAIL bp_data cyc=%0d got=%h exp=3c", i, out_data); else n_pass++;
            cyc();
        end
        // three more beats complete the 4-beat limit only if the count held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h99, 1'b1);
            n_checks++; if ({owner, ack0} !== 2'b01) $display("FAIL bp_resume beat=%0d got owner/ack0=%b exp=01", i, {owner, ack0}); else n_pass++;
            cyc();
        end
        n_checks++; if ({owner, ack1} !== 2'b11) $display("FAIL bp_limit got owner/ack1=%b exp=11", {owner, ack1}); else n_pass++;
    endtask

    task automatic test_req_drop();
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1);
        cyc();
        n_checks++; if ({owner, ack1} !== 2'b11) $display("FAIL drop_first got owner/ack1=%b exp=11", {owner, ack1}); else n_pass++;
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h44, 1'b1);
            n_checks++; if ({owner, busy, out_valid, ack0} !== 4'b1100) $display("FAIL drop_hold cyc=%0d got owner/busy/valid/ack0=%b exp=1100", i, {owner, busy, out_valid, ack0}); else n_pass++;
            cyc();
        end
        drive(1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 8'h45, 1'b1);
        n_checks++; if ({out_valid, ack1, out_last} !== 3'b111) $display("FAIL drop_resume got valid/ack1/last=%b exp=111", {out_valid, ack1, out_last}); else n_pass++;
        n_checks++; if (out_data !== 8'h45) $display("FAIL drop_resume_data got=%h exp=45", out_data); else n_pass++;
        cyc();
        n_checks++; if ({owner, busy, ack0} !== 3'b011) $display("FAIL drop_handover got owner/busy/ack0=%b exp=011", {owner, busy, ack0}); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // one single-beat grant to requester 0 leaves requester 1 favoured
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc();
        cyc();
        drive(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h60, 1'b1);
        cyc();
        n_checks++; if ({owner, ack1} !== 2'b11) $display("FAIL mid_beat1 got owner/ack1=%b exp=11", {owner, ack1}); else n_pass++;
        cyc();
        cyc();  // two beats done, third on offer
        drive(1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 8'h62, 1'b1);
        n_checks++; if ({busy, out_valid} !== 2'b11) $display("FAIL mid_pre_rst got busy/valid=%b exp=11", {busy, out_valid}); else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if ({busy, out_valid, ack0, ack1, owner} !== 5'b00000) $display("FAIL mid_async got busy/valid/ack0/ack1/owner=%b exp=00000", {busy, out_valid, ack0, ack1, owner}); else n_pass++;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_post_idle got=%b exp=0", busy); else n_pass++;
        cyc();
        n_checks++; if ({owner, busy, ack0} !== 3'b011) $display("FAIL mid_prio got owner/busy/ack0=%b exp=011", {owner, busy, ack0}); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        req0 = 1'b0; last0 = 1'b0; data0 = '0;
        req1 = 1'b0; last1 = 1'b0; data1 = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_tie_round_robin();
        test_burst_limit();
        test_backpressure();
        test_req_drop();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
